// File: rtl/rect_flip_engine.sv
// Bit-matrix engine: LOAD/CLEAR/CORNERS finish in one cycle (done next cycle); FILL sweeps one row per cycle.
// cmd_ready drops for the k rows of a FILL sweep; a command offered meanwhile waits until it is accepted.
module rect_flip_engine #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  localparam int RW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1,
  localparam int CW = ($clog2(COLS) > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [RW-1:0]        cmd_r1,
  input  logic [RW-1:0]        cmd_r2,
  input  logic [CW-1:0]        cmd_c1,
  input  logic [CW-1:0]        cmd_c2,
  input  logic [ROWS*COLS-1:0] load_data,
  output logic [ROWS*COLS-1:0] m_out,
  output logic                 done,
  output logic                 err,
  output logic                 corners_equal
);
  localparam int N = ROWS * COLS;

  typedef enum logic {IDLE, SWEEP} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_CORNERS = 2'b01, OP_FILL = 2'b10, OP_CLEAR = 2'b11} op_t;

  state_t        state;
  logic [RW-1:0] row_cnt, rhi;
  logic [CW-1:0] clo, chi;

  logic [N-1:0]  corner_mask, row_mask;
  logic [3:0]    corner_bits;
  logic          in_range, corners_same;

  // Out-of-range coordinates yield an empty mask / zero bit rather than an illegal index.
  function automatic logic [N-1:0] cell_mask(input int r, input int c);
    logic [N-1:0] m;
    m = '0;
    if (r < ROWS && c < COLS) m[N-1-(r*COLS+c)] = 1'b1;
    return m;
  endfunction

  function automatic logic cell_bit(input logic [N-1:0] m, input int r, input int c);
    return |(m & cell_mask(r, c));
  endfunction

  assign cmd_ready = (state == IDLE) && !reset;

  always_comb begin
    in_range     = 1'b0;
    corner_mask  = '0;
    corner_bits  = '0;
    corners_same = 1'b0;
    row_mask     = '0;
    in_range = (int'(cmd_r1) < ROWS) && (int'(cmd_r2) < ROWS) &&
               (int'(cmd_c1) < COLS) && (int'(cmd_c2) < COLS);
    corner_mask = cell_mask(int'(cmd_r1), int'(cmd_c1)) | cell_mask(int'(cmd_r1), int'(cmd_c2)) |
                  cell_mask(int'(cmd_r2), int'(cmd_c1)) | cell_mask(int'(cmd_r2), int'(cmd_c2));
    corner_bits = {cell_bit(m_out, int'(cmd_r1), int'(cmd_c1)), cell_bit(m_out, int'(cmd_r1), int'(cmd_c2)),
                   cell_bit(m_out, int'(cmd_r2), int'(cmd_c1)), cell_bit(m_out, int'(cmd_r2), int'(cmd_c2))};
    corners_same = (corner_bits == 4'b0000) || (corner_bits == 4'b1111);
    for (int c = 0; c < COLS; c++) begin
      if (c >= int'(clo) && c <= int'(chi)) row_mask = row_mask | cell_mask(int'(row_cnt), c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      row_cnt       <= '0;
      rhi           <= '0;
      clo           <= '0;
      chi           <= '0;
      m_out         <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      corners_equal <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (op_t'(cmd_op))
              OP_LOAD: begin
                m_out <= load_data;
                done  <= 1'b1;
              end
              OP_CLEAR: begin
                m_out <= '0;
                done  <= 1'b1;
              end
              OP_CORNERS: begin
                done <= 1'b1;
                if (!in_range) begin
                  err <= 1'b1;
                end else begin
                  m_out         <= m_out ^ corner_mask;
                  corners_equal <= corners_same;
                end
              end
              default: begin
                if (!in_range) begin
                  err  <= 1'b1;
                  done <= 1'b1;
                end else begin
                  corners_equal <= corners_same;
                  row_cnt       <= (cmd_r1 < cmd_r2) ? cmd_r1 : cmd_r2;
                  rhi           <= (cmd_r1 < cmd_r2) ? cmd_r2 : cmd_r1;
                  clo           <= (cmd_c1 < cmd_c2) ? cmd_c1 : cmd_c2;
                  chi           <= (cmd_c1 < cmd_c2) ? cmd_c2 : cmd_c1;
                  state         <= SWEEP;
                end
              end
            endcase
          end
        end
        default: begin
          m_out <= m_out ^ row_mask;
          if (row_cnt == rhi) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rect_flip_engine.sv
// Directed checks of rect_flip_engine: a 4x4 instance for the main scenarios and a 3x5 instance for range errors.
module tb_rect_flip_engine;
  logic        clk = 1'b0;
  logic        reset;
  int          vectors = 0;
  int          miscompares = 0;

  logic        cmd_valid, cmd_ready, done, err, corners_equal;
  logic [1:0]  cmd_op, cmd_r1, cmd_r2, cmd_c1, cmd_c2;
  logic [15:0] load_data, m_out;

  logic        b_valid, b_ready, b_done, b_err, b_ce;
  logic [1:0]  b_op, b_r1, b_r2;
  logic [2:0]  b_c1, b_c2;
  logic [14:0] b_load, b_m;

  localparam logic [1:0] LOAD = 2'b00, CORNERS = 2'b01, FILL = 2'b10, CLEAR = 2'b11;

  rect_flip_engine #(.ROWS(4), .COLS(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_r1(cmd_r1), .cmd_r2(cmd_r2), .cmd_c1(cmd_c1), .cmd_c2(cmd_c2), .load_data(load_data),
    .m_out(m_out), .done(done), .err(err), .corners_equal(corners_equal));

  rect_flip_engine #(.ROWS(3), .COLS(5)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(b_op),
    .cmd_r1(b_r1), .cmd_r2(b_r2), .cmd_c1(b_c1), .cmd_c2(b_c2), .load_data(b_load),
    .m_out(b_m), .done(b_done), .err(b_err), .corners_equal(b_ce));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [1:0] r1, input logic [1:0] r2,
                     input logic [1:0] c1, input logic [1:0] c2, input logic [15:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_r1 = r1; cmd_r2 = r2; cmd_c1 = c1; cmd_c2 = c2; load_data = d;
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = LOAD; cmd_r1 = '0; cmd_r2 = '0; cmd_c1 = '0; cmd_c2 = '0; load_data = '0;
    b_valid = 1'b0; b_op = LOAD; b_r1 = '0; b_r2 = '0; b_c1 = '0; b_c2 = '0; b_load = '0;
    tick();
    tick();
    chk16("rst_m_out", m_out, 16'h0000);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_ce", corners_equal, 1'b0);
    chk1("rst_ready", cmd_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk1("ready_after_rst", cmd_ready, 1'b1);

    // Four distinct corners from zero
    cmd(CORNERS, 2'd0, 2'd3, 2'd0, 2'd3, 16'h0);
    tick();
    cmd_valid = 1'b0;
    chk16("corners_9009", m_out, 16'h9009);
    chk1("corners_done", done, 1'b1);
    chk1("corners_ce", corners_equal, 1'b1);
    chk1("corners_err", err, 1'b0);
    tick();
    chk1("corners_done_drop", done, 1'b0);

    // Degenerate corners toggle a single cell
    cmd(CLEAR, 2'd0, 2'd0, 2'd0, 2'd0, 16'h0);
    tick();
    chk16("clear", m_out, 16'h0000);
    cmd(CORNERS, 2'd1, 2'd1, 2'd2, 2'd2, 16'h0);
    tick();
    chk16("single_toggle", m_out, 16'h0200);
    cmd(LOAD, 2'd0, 2'd0, 2'd0, 2'd0, 16'hFFFF);
    tick();
    chk16("load_ffff", m_out, 16'hFFFF);
    cmd(CORNERS, 2'd1, 2'd1, 2'd2, 2'd2, 16'h0);
    tick();
    chk16("single_toggle_ffff", m_out, 16'hFDFF);
    chk1("single_ce", corners_equal, 1'b1);
    cmd(CORNERS, 2'd1, 2'd1, 2'd2, 2'd3, 16'h0);
    tick();
    chk16("row_pair_toggle", m_out, 16'hFEFF);
    chk1("ce_unequal", corners_equal, 1'b0);

    // FILL across rows 1..2, cols 1..3, with a LOAD held behind it
    cmd(CLEAR, 2'd0, 2'd0, 2'd0, 2'd0, 16'h0);
    tick();
    cmd(FILL, 2'd2, 2'd1, 2'd3, 2'd1, 16'h0);
    tick();
    cmd(LOAD, 2'd0, 2'd0, 2'd0, 2'd0, 16'hA5A5);
    chk1("fill_ready_c1", cmd_ready, 1'b0);
    chk1("fill_ce", corners_equal, 1'b1);
    chk1("fill_done_c1", done, 1'b0);
    tick();
    chk1("fill_ready_c2", cmd_ready, 1'b0);
    chk16("fill_row1", m_out, 16'h0700);
    chk1("fill_done_c2", done, 1'b0);
    tick();
    chk16("fill_0770", m_out, 16'h0770);
    chk1("fill_done", done, 1'b1);
    chk1("fill_ready_back", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk16("held_load", m_out, 16'hA5A5);
    chk1("held_load_done", done, 1'b1);

    // Reset during a SWEEP abandons the FILL
    cmd(FILL, 2'd0, 2'd3, 2'd0, 2'd3, 16'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk16("sweep_rst_m_out", m_out, 16'h0000);
    chk1("sweep_rst_ready", cmd_ready, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk1("sweep_rst_no_done", done, 1'b0);
    chk1("sweep_rst_ready_back", cmd_ready, 1'b1);
    tick();
    chk1("sweep_rst_no_done2", done, 1'b0);
    chk16("sweep_rst_m_hold", m_out, 16'h0000);

    // Back-to-back single-cycle commands
    cmd(LOAD, 2'd0, 2'd0, 2'd0, 2'd0, 16'h1234);
    tick();
    chk16("b2b_load", m_out, 16'h1234);
    chk1("b2b_done1", done, 1'b1);
    cmd(CLEAR, 2'd0, 2'd0, 2'd0, 2'd0, 16'h0);
    tick();
    chk16("b2b_clear", m_out, 16'h0000);
    chk1("b2b_done2", done, 1'b1);
    cmd(CORNERS, 2'd0, 2'd1, 2'd0, 2'd1, 16'h0);
    tick();
    cmd_valid = 1'b0;
    chk16("b2b_corners", m_out, 16'hCC00);
    chk1("b2b_done3", done, 1'b1);
    tick();
    chk1("b2b_done_drop", done, 1'b0);

    // 3x5 instance: range errors leave matrix and flag untouched
    b_valid = 1'b1; b_op = CORNERS; b_r1 = 2'd0; b_r2 = 2'd0; b_c1 = 3'd0; b_c2 = 3'd0;
    tick();
    chk16("b_corner00", {1'b0, b_m}, 16'h4000);
    chk1("b_ce_set", b_ce, 1'b1);
    chk1("b_err_ok", b_err, 1'b0);
    b_r2 = 2'd3;
    tick();
    chk1("b_err_row", b_err, 1'b1);
    chk1("b_done_row", b_done, 1'b1);
    chk16("b_m_hold", {1'b0, b_m}, 16'h4000);
    chk1("b_ce_hold", b_ce, 1'b1);
    b_op = FILL; b_r2 = 2'd2; b_c2 = 3'd5;
    tick();
    b_valid = 1'b0;
    chk1("b_err_col", b_err, 1'b1);
    chk1("b_done_col", b_done, 1'b1);
    chk1("b_ready_idle", b_ready, 1'b1);
    chk16("b_m_hold2", {1'b0, b_m}, 16'h4000);
    chk1("b_ce_hold2", b_ce, 1'b1);
    tick();
    chk1("b_err_drop", b_err, 1'b0);
    chk1("b_done_drop", b_done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rect_flip_engine.md
RECT_FLIP_ENGINE -- requirements
Module: rect_flip_engine

Interface
REQ-001 Parameters SHALL be:
- ROWS, default 4, matrix row count (>=2).
- COLS, default 4, matrix column count (>=2).
- RW, derived as max(1, clog2(ROWS)), row-index width.
- CW, derived as max(1, clog2(COLS)), column-index width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on the rising edge.
- reset, in, 1, asynchronous, active-high.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, engine can accept a command.
- cmd_op, in, 2, operation: 00 LOAD, 01 CORNERS, 10 FILL, 11 CLEAR.
- cmd_r1, cmd_r2, in, RW each, rectangle rows.
- cmd_c1, cmd_c2, in, CW each, rectangle columns.
- load_data, in, ROWS*COLS, matrix value for LOAD.
- m_out, out, ROWS*COLS, registered matrix.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, one-cycle out-of-range pulse, coincident with done.
- corners_equal, out, 1, registered corner-uniformity flag.
REQ-003 Cell (r,c) SHALL map to bit index ROWS*COLS-1-(r*COLS+c), so (0,0) is the MSB.
REQ-004 Clock SHALL be clk; reset SHALL be asynchronous and active-high, named reset.

Function
REQ-005 States SHALL be IDLE and SWEEP.
REQ-006 cmd_ready SHALL be 1 only when state is IDLE and reset is low.
REQ-007 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; all command fields are sampled on that edge only.
REQ-008 Range check at accept: if any row index >= ROWS or any column index >= COLS for CORNERS or FILL, then m_out is unchanged, err=1 and done=1 in the next cycle, and the state stays IDLE.
REQ-009 LOAD SHALL set m_out to load_data on the accept edge.
REQ-010 CLEAR SHALL set m_out to 0 on the accept edge.
REQ-011 CORNERS SHALL XOR m_out with the OR of the masks for (r1,c1), (r1,c2), (r2,c1) and (r2,c2) on the accept edge; a duplicated coordinate toggles once.
REQ-012 For LOAD, CLEAR and CORNERS, done SHALL be 1 in the cycle after the accept edge, the state stays IDLE, and a new command is accepted every cycle.
REQ-013 FILL accept SHALL latch:
- rlo = min(r1,r2), rhi = max(r1,r2).
- clo = min(c1,c2), chi = max(c1,c2).
- row counter = rlo.
- next state = SWEEP.
REQ-014 In SWEEP, each edge SHALL XOR the cells (row counter, clo..chi) into m_out.
- If row counter == rhi: go to IDLE and set done=1 for the next cycle.
- Otherwise: increment the row counter.
REQ-015 FILL latency: a FILL spanning k rows SHALL hold cmd_ready low for exactly k cycles after accept; done rises after the k-th SWEEP edge.
REQ-016 corners_equal SHALL be updated only on CORNERS or FILL accept: 1 if the four pre-operation corner bits are all equal, else 0. It holds its value otherwise and is unchanged by err commands.
REQ-017 done and err SHALL be 0 in every cycle not specified above.
REQ-018 cmd_valid while cmd_ready=0 SHALL have no effect; the command must be held until it is accepted.

Reset
REQ-019 While reset=1, the block SHALL force:
- m_out=0, done=0, err=0, corners_equal=0.
- state IDLE, row counter 0, cmd_ready=0.
REQ-020 Reset asserted during SWEEP SHALL abandon the FILL: no done pulse, and m_out=0.
REQ-021 The first command SHALL be accepted on the first edge after reset deasserts with cmd_valid=1.

Verification (ROWS=COLS=4 unless stated)
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then CORNERS r1=0,r2=3,c1=0,c2=3 -> m_out=16'h9009, done one cycle, corners_equal=1.
- From zero, CORNERS r1=r2=1, c1=c2=2 -> m_out=16'h0200 (single toggle); then LOAD 16'hFFFF, CORNERS same coordinates -> 16'hFDFF, corners_equal=1.
- From zero, FILL r1=2,r2=1,c1=3,c2=1 -> cmd_ready low 2 cycles, m_out=16'h0770, done 1 cycle; cmd_valid held throughout is accepted only afterwards.
- Reset asserted after first SWEEP edge of FILL r1=0,r2=3 -> m_out=0, no done, cmd_ready=1 after release.
- ROWS=3, COLS=5: CORNERS r2=3 -> err=1, done=1, m_out and corners_equal unchanged.
- Back-to-back LOAD 16'h1234, CLEAR, CORNERS (0,0),(0,1),(1,0),(1,1) on consecutive cycles -> m_out 16'h1234, 0, 16'hCC00; done high 3 cycles.
